data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port-write / single-port-read data memory between two requesters:
//  port 0 is the CPU load/store stage and port 1 is the debug/DMA loader.
//  Grants at most one access per cycle, round-robin, with an optional lock for atomic
//  read-modify-write sequences. Checks alignment and range before the memory is touched.
//  Returns read data one cycle after the grant, tagged to the requester that issued it.
// PARAMETERS
//  SIZE     4096  memory size in bytes; must match the data memory instance; valid words 0..SIZE/4-1
// PORTS
//  clk             in   1   system clock, all logic on posedge
//  reset           in   1   synchronous, active-low reset (0 = reset)
//  pN_req          in   1   N=0,1: access request, held until granted
//  pN_we           in   1   1 = write, 0 = read
//  pN_lock         in   1   keep ownership after this grant (atomic sequence)
//  pN_addr         in   32  byte address, word aligned
//  pN_wdata        in   32  write data
//  pN_gnt          out  1   combinational: this cycle's request accepted
//  pN_rvalid       out  1   read response valid (cycle after grant)
//  pN_rdata        out  32  read data, 0 when not valid
//  pN_err          out  1   pulses with the response: misaligned or out-of-range
//  mem_write_en    out  1   to memory write_en
//  mem_write_addr  out  32  to memory write_addr (byte address passed through)
//  mem_write_data  out  32  to memory write_data
//  mem_read_addr   out  32  to memory read_addrA
//  mem_read_data   in   32  from memory read_dataA, registered in memory (1-cycle latency)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=ARB, rr_ptr=0 (port 0 favoured), lock owner cleared,
//   pending read cleared. All outputs 0 during and after reset until a new grant.
//  Reset mid-operation: an in-flight read is dropped; no rvalid/err is produced for it.
//  FSM ARB: if exactly one req, grant it. If both, grant port rr_ptr.
//   After any grant, rr_ptr <= other port.
//   If the granted port has lock=1, next state is LOCK_P0 or LOCK_P1.
//  FSM LOCK_Pn: only port n is granted; the other port's gnt=0 even if it requests.
//   Stay while port n is granted with lock=1. Return to ARB on the first grant with lock=0.
//   Also return to ARB on any cycle where port n has req=0.
//  Grant is combinational from req/state/rr_ptr. A requester drops or changes req
//   only after seeing gnt at a clock edge.
//  Granted access is checked first: err_cond = addr[1:0]!=0 || addr[31:2] >= SIZE/4.
//  Write without err_cond:
//   mem_write_en=1, mem_write_addr=addr, mem_write_data=wdata, in the grant cycle.
//  Write with err_cond: mem_write_en stays 0; pN_err=1 on the next cycle; no rvalid.
//  Read: mem_read_addr=addr in the grant cycle.
//   Next cycle: pN_rvalid=1 and pN_rdata=mem_read_data.
//   If err_cond: pN_rvalid=1, pN_rdata=0, pN_err=1.
//  Write-then-read to one address on consecutive cycles returns the new data,
//   because the memory writes at the first edge and reads at the second.
//  mem_read_addr holds its last value when idle; mem_write_en=0 when no write is granted.
//  Only one port has rvalid/err high in any cycle; a response never overlaps itself.
//   Back-to-back reads give one response per cycle.
// STRUCTURE
//  Shared package dmem_pkg:
//   arb_state_t {ARB, LOCK_P0, LOCK_P1};
//   constants WORD_BYTES=4, NUM_PORTS=2.
//  One sub-module, dmem_addr_check: combinational err_cond from addr and SIZE.
//   Instantiated once, on the muxed granted address.
//  Registers: state, rr_ptr, resp_valid, resp_port, resp_is_read, resp_err.
// TESTING
//  Both ports req read of 0x10 in the first cycle after reset -> p0_gnt=1, p1_gnt=0;
//   next cycle p1_gnt=1; rvalid arrives on p0 then on p1.
//  p1 writes 0xDEADBEEF to 0x20, then p0 reads 0x20 the next cycle ->
//   p0_rvalid=1, p0_rdata=0xDEADBEEF.
//  p0 read with lock=1, then write with lock=0, while p1_req is held ->
//   p1_gnt=0 for both cycles, then p1_gnt=1 in the third cycle.
//  p0 write to 0x22 (misaligned) and then to 0x1000 with SIZE=4096 ->
//   mem_write_en=0 both times; p0_err pulses each next cycle; memory is unchanged.
//  reset driven 0 in the cycle after a p1 read grant ->
//   p1_rvalid never asserts; rr_ptr=0; a simultaneous request after reset grants p0.
//  Back-to-back reads, p0 to 0x0, 0x4, 0x8 ->
//   three consecutive p0_rvalid cycles in address order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory arbiter.
// Imported by the address checker and the arbiter top.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    LOCK_P0 = 2'd1,
    LOCK_P1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Flags a granted access that is misaligned or
// falls outside the data memory word range.
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter int SIZE = 4096
) (
  input  logic [31:0] addr,
  output logic        err_cond
);

  localparam logic [29:0] WORDS =
    30'(SIZE / WORD_BYTES);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = addr[1:0] != 2'b00;
  assign out_of_range = addr[31:2] >= WORDS;
  assign err_cond     = misaligned | out_of_range;

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter with lock for the data memory.
// Checks each granted access and tags the response to its port.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_write_en,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data
);

  arb_state_t  state;
  arb_state_t  state_n;
  logic        rr_ptr;
  logic        g0_raw;
  logic        g1_raw;
  logic        g0;
  logic        g1;
  logic        any_gnt;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        err_cond;
  logic        wr_ok;
  logic        rd_go;
  logic [31:0] last_raddr;
  logic        resp_valid;
  logic        resp_port;
  logic        resp_is_read;
  logic        resp_err;
  logic        rsp_live;
  logic [31:0] rd_word;

  always_comb begin
    g0_raw = 1'b0;
    g1_raw = 1'b0;
    unique case (state)
      ARB: begin
        g0_raw = p0_req & (~p1_req | ~rr_ptr);
        g1_raw = p1_req & (~p0_req | rr_ptr);
      end
      LOCK_P0: g0_raw = p0_req;
      LOCK_P1: g1_raw = p1_req;
      default: ;
    endcase
  end

  // No grants while reset is held, so every output stays quiet.
  assign g0      = reset & g0_raw;
  assign g1      = reset & g1_raw;
  assign p0_gnt  = g0;
  assign p1_gnt  = g1;
  assign any_gnt = g0 | g1;

  always_comb begin
    state_n = state;
    unique case (state)
      ARB: begin
        if (g0 && p0_lock)
          state_n = LOCK_P0;
        else if (g1 && p1_lock)
          state_n = LOCK_P1;
      end
      LOCK_P0: begin
        if (!p0_req || !p0_lock)
          state_n = ARB;
      end
      LOCK_P1: begin
        if (!p1_req || !p1_lock)
          state_n = ARB;
      end
      default: state_n = ARB;
    endcase
  end

  assign sel_we    = g1 ? p1_we    : p0_we;
  assign sel_addr  = g1 ? p1_addr  : p0_addr;
  assign sel_wdata = g1 ? p1_wdata : p0_wdata;

  dmem_addr_check #(
    .SIZE(SIZE)
  ) u_chk (
    .addr    (sel_addr),
    .err_cond(err_cond)
  );

  assign wr_ok = any_gnt & sel_we & ~err_cond;
  assign rd_go = any_gnt & ~sel_we;

  assign mem_write_en   = wr_ok;
  assign mem_write_addr = wr_ok ? sel_addr  : '0;
  assign mem_write_data = wr_ok ? sel_wdata : '0;
  assign mem_read_addr  = rd_go ? sel_addr  : last_raddr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ARB;
      rr_ptr       <= 1'b0;
      last_raddr   <= '0;
      resp_valid   <= 1'b0;
      resp_port    <= 1'b0;
      resp_is_read <= 1'b0;
      resp_err     <= 1'b0;
    end else begin
      state <= state_n;
      if (g0)
        rr_ptr <= 1'b1;
      else if (g1)
        rr_ptr <= 1'b0;
      if (rd_go)
        last_raddr <= sel_addr;
      // Clean writes complete silently; reads and bad accesses respond.
      resp_valid   <= any_gnt & (~sel_we | err_cond);
      resp_port    <= g1;
      resp_is_read <= ~sel_we;
      resp_err     <= any_gnt & err_cond;
    end
  end

  assign rsp_live = reset & resp_valid;
  assign rd_word  = resp_err ? '0 : mem_read_data;

  assign p0_rvalid = rsp_live & resp_is_read & ~resp_port;
  assign p1_rvalid = rsp_live & resp_is_read & resp_port;
  assign p0_err    = rsp_live & resp_err & ~resp_port;
  assign p1_err    = rsp_live & resp_err & resp_port;
  assign p0_rdata  = p0_rvalid ? rd_word : '0;
  assign p1_rdata  = p1_rvalid ? rd_word : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a
// registered-read memory model behind it.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_lock;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_lock;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;
  logic        mem_write_en;
  logic [31:0] mem_write_addr, mem_write_data;
  logic [31:0] mem_read_addr, mem_read_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   mem [0:1023];
  logic [1023:0] wr_flag = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_write_addr[11:2]]     <= mem_write_data;
      wr_flag[mem_write_addr[11:2]] <= 1'b1;
    end
    mem_read_data <= wr_flag[mem_read_addr[11:2]] ?
      mem[mem_read_addr[11:2]] :
      32'h1000_0000 + {22'd0, mem_read_addr[11:2]};
  end

  data_mem_arbiter #(.SIZE(4096)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_write_en(mem_write_en),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data)
  );

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_lock = 0;
    p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0;
    p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic test_reset();
    logic [200:0] outs;
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
            p0_err, p1_err, mem_write_en,
            mem_write_addr, mem_write_data,
            mem_read_addr, p0_rdata, p1_rdata};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outs got=%h exp=0", outs);
    end
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    p0_req = 1; p0_addr = 32'h10;
    p1_req = 1; p1_addr = 32'h10;
    #1;
    vectors++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_first_gnt got=%b exp=10", {p0_gnt, p1_gnt});
    end
    vectors++;
    if (mem_read_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL rr_raddr got=%h exp=10", mem_read_addr);
    end
    @(negedge clk);
    vectors++;
    if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, 32'h1000_0004}) begin
      miscompares++;
      $display("FAIL rr_p0_resp got=%b%b %h exp=10 10000004",
               p0_rvalid, p1_rvalid, p0_rdata);
    end
    p0_req = 0;
    #1;
    vectors++;
    if ({p0_gnt, p1_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_second_gnt got=%b exp=01", {p0_gnt, p1_gnt});
    end
    @(negedge clk);
    vectors++;
    if ({p0_rvalid, p1_rvalid, p1_rdata} !== {2'b01, 32'h1000_0004}) begin
      miscompares++;
      $display("FAIL rr_p1_resp got=%b%b %h exp=01 10000004",
               p0_rvalid, p1_rvalid, p1_rdata);
    end
    p1_req = 0;
    #1;
    vectors++;
    if ({mem_read_addr, p0_rdata, mem_write_en} !== {32'h10, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_hold got=%h %h %b exp=10 0 0",
               mem_read_addr, p0_rdata, mem_write_en);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    p1_req = 1; p1_we = 1;
    p1_addr = 32'h20; p1_wdata = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if ({p1_gnt, mem_write_en, mem_write_addr, mem_write_data}
        !== {2'b11, 32'h20, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL wr_drive got=%b%b %h %h exp=11 20 deadbeef",
               p1_gnt, mem_write_en, mem_write_addr, mem_write_data);
    end
    @(negedge clk);
    p1_req = 0; p1_we = 0;
    p0_req = 1; p0_addr = 32'h20;
    #1;
    vectors++;
    if ({p0_gnt, mem_write_en, p1_rvalid, p1_err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wr_then_rd got=%b%b%b%b exp=1000",
               p0_gnt, mem_write_en, p1_rvalid, p1_err);
    end
    @(negedge clk);
    vectors++;
    if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL raw_data got=%b %h exp=1 deadbeef",
               p0_rvalid, p0_rdata);
    end
    p0_req = 0;
  endtask

  task automatic test_lock();
    @(negedge clk);
    p1_req = 1; p1_addr = 32'h8;
    #1;
    vectors++;
    if (p1_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL lk_pre_gnt got=%b exp=1", p1_gnt);
    end
    @(negedge clk);
    vectors++;
    if (p1_rdata !== 32'h1000_0002) begin
      miscompares++;
      $display("FAIL lk_pre_data got=%h exp=10000002", p1_rdata);
    end
    p0_req = 1; p0_lock = 1; p0_addr = 32'h0;
    p1_req = 1; p1_addr = 32'h4;
    #1;
    vectors++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL lk_gnt1 got=%b exp=10", {p0_gnt, p1_gnt});
    end
    @(negedge clk);
    vectors++;
    if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h1000_0000}) begin
      miscompares++;
      $display("FAIL lk_rd_data got=%b %h exp=1 10000000",
               p0_rvalid, p0_rdata);
    end
    p0_we = 1; p0_lock = 0;
    p0_addr = 32'h30; p0_wdata = 32'h1234_5678;
    #1;
    vectors++;
    if ({p0_gnt, p1_gnt, mem_write_en} !== 3'b101) begin
      miscompares++;
      $display("FAIL lk_gnt2 got=%b exp=101",
               {p0_gnt, p1_gnt, mem_write_en});
    end
    @(negedge clk);
    p0_req = 0; p0_we = 0;
    #1;
    vectors++;
    if ({p0_gnt, p1_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL lk_release got=%b exp=01", {p0_gnt, p1_gnt});
    end
    @(negedge clk);
    vectors++;
    if ({p1_rvalid, p1_rdata} !== {1'b1, 32'h1000_0001}) begin
      miscompares++;
      $display("FAIL lk_p1_data got=%b %h exp=1 10000001",
               p1_rvalid, p1_rdata);
    end
    p1_req = 0;
  endtask

  task automatic test_errors();
    @(negedge clk);
    p0_req = 1; p0_we = 1;
    p0_addr = 32'h22; p0_wdata = 32'h5555_5555;
    #1;
    vectors++;
    if ({p0_gnt, mem_write_en} !== 2'b10) begin
      miscompares++;
      $display("FAIL er_misal_we got=%b exp=10", {p0_gnt, mem_write_en});
    end
    @(negedge clk);
    vectors++;
    if ({p0_err, p0_rvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL er_misal_err got=%b exp=10", {p0_err, p0_rvalid});
    end
    p0_addr = 32'h1000;
    #1;
    vectors++;
    if ({p0_gnt, mem_write_en} !== 2'b10) begin
      miscompares++;
      $display("FAIL er_range_we got=%b exp=10", {p0_gnt, mem_write_en});
    end
    @(negedge clk);
    vectors++;
    if ({p0_err, p0_rvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL er_range_err got=%b exp=10", {p0_err, p0_rvalid});
    end
    p0_we = 0;
    @(negedge clk);
    vectors++;
    if ({p0_rvalid, p0_err, p0_rdata} !== {2'b11, 32'h0}) begin
      miscompares++;
      $display("FAIL er_read got=%b%b %h exp=11 0",
               p0_rvalid, p0_err, p0_rdata);
    end
    p0_req = 0;
    @(negedge clk);
    vectors++;
    if ({p0_err, p0_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL er_clear got=%b exp=00", {p0_err, p0_rvalid});
    end
    vectors++;
    if (mem[8] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL er_mem_kept got=%h exp=deadbeef", mem[8]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    p1_req = 1; p1_addr = 32'h4;
    #1;
    vectors++;
    if (p1_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_gnt got=%b exp=1", p1_gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    p1_req = 0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({p1_rvalid, p1_err} !== 2'b00) begin
        miscompares++;
        $display("FAIL rm_dropped got=%b exp=00", {p1_rvalid, p1_err});
      end
    end
    reset = 1'b1;
    p0_req = 1; p0_addr = 32'h0;
    p1_req = 1; p1_addr = 32'h8;
    #1;
    vectors++;
    if ({p0_gnt, p1_gnt, p1_rvalid} !== 3'b100) begin
      miscompares++;
      $display("FAIL rm_after_gnt got=%b exp=100",
               {p0_gnt, p1_gnt, p1_rvalid});
    end
    @(negedge clk);
    vectors++;
    if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h1000_0000}) begin
      miscompares++;
      $display("FAIL rm_p0_data got=%b %h exp=1 10000000",
               p0_rvalid, p0_rdata);
    end
    p0_req = 0;
    @(negedge clk);
    vectors++;
    if ({p1_rvalid, p1_rdata} !== {1'b1, 32'h1000_0002}) begin
      miscompares++;
      $display("FAIL rm_p1_data got=%b %h exp=1 10000002",
               p1_rvalid, p1_rdata);
    end
    p1_req = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h1000_0000;
    exp_d[1] = 32'h1000_0001;
    exp_d[2] = 32'h1000_0002;
    @(negedge clk);
    p0_req = 1; p0_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (p0_gnt !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gnt%0d got=%b exp=1", i, p0_gnt);
      end
      @(negedge clk);
      vectors++;
      if ({p0_rvalid, p0_rdata} !== {1'b1, exp_d[i]}) begin
        miscompares++;
        $display("FAIL b2b_data%0d got=%b %h exp=1 %h",
                 i, p0_rvalid, p0_rdata, exp_d[i]);
      end
      p0_addr = p0_addr + 32'h4;
      if (i == 2) p0_req = 0;
    end
    @(negedge clk);
    vectors++;
    if (p0_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end got=%b exp=0", p0_rvalid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
